// File: rtl/sce_ramclr_if.sv
// RAM port between the SCE scrub sequencer (master) and the shared-RAM arbiter (slave).
interface sce_ramclr_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          clr_req;
    logic          clr_gnt;
    logic          clr_we;
    logic          clr_re;
    logic [AW-1:0] clr_addr;
    logic [DW-1:0] clr_wdata;
    logic [DW-1:0] clr_rdata;

    modport master (
        output clr_req, clr_we, clr_re, clr_addr, clr_wdata,
        input  clr_gnt, clr_rdata
    );

    modport slave (
        input  clr_req, clr_we, clr_re, clr_addr, clr_wdata,
        output clr_gnt, clr_rdata
    );
endinterface

// File: rtl/sce_ramclr.sv
// sce_ramclr: sweeps every SCE shared-RAM word to CLRPAT after ar_clrram, abortable by ar_reset.
// Define SCE_RAMCLR_VERIFY_EN to build the read-back verify pass and mismatch counter.
module sce_ramclr #(
    parameter int            AW       = 8,        // tracks scedma_pkg::AW
    parameter int            DW       = 32,
    parameter int            RAMDEPTH = 2**AW,
    parameter logic [DW-1:0] CLRPAT   = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ar_clrram,
    input  logic         ar_reset,
    sce_ramclr_if.master bus,
    output logic         sr_clrbusy,
    output logic         fr_clrdone,
    output logic         fr_clrerr,
    output logic [15:0]  sr_clrerrcnt
);
    localparam logic [AW-1:0] LAST = AW'(RAMDEPTH - 1);

    typedef enum logic [2:0] {IDLE, SWEEP, VERIFY, DRAIN, DONE} state_e;

    state_e        state_q, state_d;
    logic          req_q, req_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          busy_q, done_q, err_q;
    logic          err_d;
    logic          we, re;

    assign we = req_q & bus.clr_gnt & (state_q == SWEEP);
`ifdef SCE_RAMCLR_VERIFY_EN
    assign re = req_q & bus.clr_gnt & (state_q == VERIFY);
`else
    assign re = 1'b0;
`endif

    assign bus.clr_req   = req_q;
    assign bus.clr_we    = we;
    assign bus.clr_re    = re;
    assign bus.clr_addr  = addr_q;
    assign bus.clr_wdata = CLRPAT;
    assign sr_clrbusy    = busy_q;
    assign fr_clrdone    = done_q;
    assign fr_clrerr     = err_q;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: if (ar_clrram) begin
                state_d = SWEEP;
                req_d   = 1'b1;
                addr_d  = '0;
            end
            SWEEP: if (we) begin
                // Wraps to 0 on the last word when RAMDEPTH == 2**AW; state leaves SWEEP anyway.
                addr_d = addr_q + AW'(1);
                if (addr_q == LAST) begin
`ifdef SCE_RAMCLR_VERIFY_EN
                    state_d = VERIFY;
                    addr_d  = '0;
`else
                    state_d = DONE;
                    req_d   = 1'b0;
`endif
                end
            end
`ifdef SCE_RAMCLR_VERIFY_EN
            VERIFY: if (re) begin
                addr_d = addr_q + AW'(1);
                if (addr_q == LAST) begin
                    state_d = DRAIN;
                    req_d   = 1'b0;
                end
            end
            DRAIN:   state_d = DONE;
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Soft abort beats everything, including a same-cycle start.
        if (ar_reset) begin
            state_d = IDLE;
            req_d   = 1'b0;
            addr_d  = '0;
        end
    end

`ifdef SCE_RAMCLR_VERIFY_EN
    logic        rd_vld_q;
    logic [15:0] cnt_q, cnt_d;

    // Read data lands one cycle after clr_re; the last datum is compared during DRAIN.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE && ar_clrram && !ar_reset)
            cnt_d = '0;
        else if (rd_vld_q && bus.clr_rdata != CLRPAT && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
        err_d = (state_d == DONE) && (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            rd_vld_q <= re;
            cnt_q    <= cnt_d;
        end
    end

    assign sr_clrerrcnt = cnt_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^bus.clr_rdata;
    assign err_d        = 1'b0;
    assign sr_clrerrcnt = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_sce_ramclr.sv
// Scoreboard bench for sce_ramclr: RAMDEPTH=8, model pushes expected strobes/done pulses, monitor pops.
module tb_sce_ramclr;
    localparam int          AW  = 3;
    localparam int          DW  = 32;
    localparam logic [31:0] PAT = 32'hA5A5_5A5A;
`ifdef SCE_RAMCLR_VERIFY_EN
    localparam bit VEN = 1'b1;
`else
    localparam bit VEN = 1'b0;
`endif
    localparam int DONE_LAT = VEN ? 18 : 9;

    typedef struct { bit rd; logic [2:0] addr; int cyc; } ev_t;
    typedef struct { bit err; logic [15:0] cnt; int cyc; } dn_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ar_clrram = 1'b0;
    logic        ar_reset = 1'b0;
    logic        sr_clrbusy, fr_clrdone, fr_clrerr;
    logic [15:0] sr_clrerrcnt;

    sce_ramclr_if #(.AW(AW), .DW(DW)) bus ();

    sce_ramclr #(.AW(AW), .DW(DW), .RAMDEPTH(8), .CLRPAT(PAT)) dut (
        .clk(clk), .reset(reset), .ar_clrram(ar_clrram), .ar_reset(ar_reset), .bus(bus),
        .sr_clrbusy(sr_clrbusy), .fr_clrdone(fr_clrdone), .fr_clrerr(fr_clrerr),
        .sr_clrerrcnt(sr_clrerrcnt)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   vecs = 0;
    int   errs = 0;
    int   gmode = 0;
    bit   chk_idle = 1'b0;
    logic [7:0]  bad_mask = '0;
    logic [31:0] mem [8];
    ev_t  ev_q[$];
    dn_t  dn_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: addresses flagged in bad_mask read back a corrupted word.
    initial for (int i = 0; i < 8; i++) mem[i] = $urandom;
    always @(posedge clk) begin
        if (bus.clr_we) mem[bus.clr_addr] <= bus.clr_wdata;
        if (bus.clr_re) bus.clr_rdata <= bad_mask[bus.clr_addr] ? 32'h1 : mem[bus.clr_addr];
    end

    initial begin
        bus.clr_gnt = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (gmode)
                0:       bus.clr_gnt = 1'b1;
                1:       bus.clr_gnt = ~bus.clr_gnt;
                default: bus.clr_gnt = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Spec-level model of one run: 8 writes, 8 reads if verify, then one done pulse.
    // With continuous grant the cycle of every event is known; cut drops events after an abort/reset.
    task automatic push_run(input int t0, input int cut, input bit timed);
        for (int a = 0; a < 8; a++)
            if (cut < 0 || 1 + a <= cut) ev_q.push_back('{1'b0, 3'(a), timed ? t0 + 1 + a : -1});
        if (VEN)
            for (int a = 0; a < 8; a++)
                if (cut < 0 || 9 + a <= cut) ev_q.push_back('{1'b1, 3'(a), timed ? t0 + 9 + a : -1});
        if (cut < 0)
            dn_q.push_back('{VEN && (bad_mask != 0), VEN ? 16'($countones(bad_mask)) : 16'd0,
                             timed ? t0 + DONE_LAT : -1});
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin @(posedge clk); #1; end
    endtask

    task automatic start(input int cut, input bit timed, output int t0);
        @(posedge clk); #1;
        t0 = cyc;
        push_run(t0, cut, timed);
        ar_clrram = 1'b1;
        @(posedge clk); #1;
        ar_clrram = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        do begin @(negedge clk); n++; end while (sr_clrbusy && n < 300);
        check({nm, "_timeout"}, 32'(sr_clrbusy), 32'd0);
        @(posedge clk); #1;
        check({nm, "_strobes_left"}, ev_q.size(), 0);
        check({nm, "_dones_left"}, dn_q.size(), 0);
    endtask

    // Monitor: every strobe and done pulse is matched against the head of its queue.
    initial begin
        ev_t e;
        dn_t d;
        forever begin
            @(negedge clk);
            if (chk_idle) begin
                check("busy_after_done", 32'(sr_clrbusy), 32'd0);
                chk_idle = 1'b0;
            end
            if (bus.clr_we || bus.clr_re) begin
                check("strobe_expected", 32'(ev_q.size() > 0), 32'd1);
                if (ev_q.size() > 0) begin
                    e = ev_q.pop_front();
                    check("strobe_kind_re", 32'(bus.clr_re), 32'(e.rd));
                    check("strobe_kind_we", 32'(bus.clr_we), 32'(!e.rd));
                    check("strobe_addr", 32'(bus.clr_addr), 32'(e.addr));
                    if (!e.rd) check("wdata", bus.clr_wdata, PAT);
                    if (e.cyc >= 0) check("strobe_cycle", cyc, e.cyc);
                end
            end
            if (fr_clrdone) begin
                check("done_expected", 32'(dn_q.size() > 0), 32'd1);
                if (dn_q.size() > 0) begin
                    d = dn_q.pop_front();
                    check("done_err", 32'(fr_clrerr), 32'(d.err));
                    check("done_errcnt", 32'(sr_clrerrcnt), 32'(d.cnt));
                    if (d.cyc >= 0) check("done_cycle", cyc, d.cyc);
                end
                chk_idle = 1'b1;
            end else if (fr_clrerr) begin
                check("err_without_done", 32'(fr_clrerr), 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors so far", vecs);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_req", 32'(bus.clr_req), 32'd0);
        check("rst_addr", 32'(bus.clr_addr), 32'd0);
        check("rst_busy", 32'(sr_clrbusy), 32'd0);
        check("rst_done", 32'(fr_clrdone), 32'd0);
        check("rst_err", 32'(fr_clrerr), 32'd0);
        check("rst_cnt", 32'(sr_clrerrcnt), 32'd0);
        check("rst_we", 32'(bus.clr_we), 32'd0);

        // Continuous grant, exact latency.
        gmode = 0; bad_mask = '0;
        start(-1, 1'b1, t0);
        check("start_req", 32'(bus.clr_req), 32'd1);
        check("start_busy", 32'(sr_clrbusy), 32'd1);
        wait_idle("full_run");

        // Grant toggling: order and no-skip still hold.
        gmode = 1;
        start(-1, 1'b0, t0);
        wait_idle("toggle_gnt");

        // Corrupted words at 3 and 5; count survives into IDLE.
        gmode = 0; bad_mask = 8'h28;
        start(-1, 1'b1, t0);
        wait_idle("bad_words");
        check("cnt_hold_idle", 32'(sr_clrerrcnt), VEN ? 32'd2 : 32'd0);

        // Soft abort after the 4th write, then a clean restart.
        bad_mask = '0;
        start(4, 1'b1, t0);
        goto(t0 + 4);
        ar_reset = 1'b1;
        goto(t0 + 5);
        ar_reset = 1'b0;
        @(negedge clk);
        check("abort_req", 32'(bus.clr_req), 32'd0);
        check("abort_busy", 32'(sr_clrbusy), 32'd0);
        check("abort_addr", 32'(bus.clr_addr), 32'd0);
        wait_idle("abort");
        start(-1, 1'b1, t0);
        wait_idle("restart");

        // Extra start mid-sweep is ignored.
        start(-1, 1'b1, t0);
        goto(t0 + 3);
        ar_clrram = 1'b1;
        goto(t0 + 4);
        ar_clrram = 1'b0;
        wait_idle("restart_ignored");

        // Start and abort together in IDLE: abort wins.
        @(posedge clk); #1;
        ar_clrram = 1'b1; ar_reset = 1'b1;
        @(posedge clk); #1;
        ar_clrram = 1'b0; ar_reset = 1'b0;
        @(negedge clk);
        check("both_busy", 32'(sr_clrbusy), 32'd0);
        check("both_req", 32'(bus.clr_req), 32'd0);

        // Hard reset mid-VERIFY (mid-SWEEP without verify) with one mismatch counted.
        bad_mask = 8'h04;
        begin
            int r;
            r = VEN ? 14 : 4;
            start(r, 1'b1, t0);
            goto(t0 + r);
            if (VEN) begin
                @(negedge clk);
                check("cnt_before_reset", 32'(sr_clrerrcnt), 32'd1);
            end
            reset = 1'b1;
            goto(t0 + r + 1);
            reset = 1'b0;
        end
        @(negedge clk);
        check("hrst_req", 32'(bus.clr_req), 32'd0);
        check("hrst_addr", 32'(bus.clr_addr), 32'd0);
        check("hrst_busy", 32'(sr_clrbusy), 32'd0);
        check("hrst_done", 32'(fr_clrdone), 32'd0);
        check("hrst_err", 32'(fr_clrerr), 32'd0);
        check("hrst_cnt", 32'(sr_clrerrcnt), 32'd0);
        wait_idle("hard_reset");

        // Random grant and random corrupted words.
        gmode = 2;
        for (int k = 0; k < 8; k++) begin
            bad_mask = 8'($urandom_range(0, 255));
            start(-1, 1'b0, t0);
            wait_idle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
